// File: rtl/ddr2_resp_pkg.sv
// ----------------------------------------------------------------------------
// ddr2_resp_pkg
// Shared types and helpers for the ddr2_port_responder slice.
//   resp_state_t : responder FSM states
//   grant_t      : which channel completed most recently (round-robin memory)
//   LFSR_SEED / LFSR_TAPS : constants for the optional latency-jitter LFSR
//   byte_to_word : byte address -> RAM word index (field extract, then wrap)
// ----------------------------------------------------------------------------
package ddr2_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_WAIT = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } resp_state_t;

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Takes the idx_w address bits above the byte offset and folds them into
    // the RAM depth, so addresses past the end of a line wrap to its start.
    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr,
                                                 input int unsigned idx_w,
                                                 input int unsigned depth);
        logic [31:0] field;
        field = (byte_addr >> 2) & ((32'd1 << idx_w) - 32'd1);
        return field % depth;
    endfunction

endpackage

// File: rtl/ddr2_port_responder_if.sv
// ----------------------------------------------------------------------------
// ddr2_port_responder_if
// Two-channel write/read conduit between the frame-buffer initiator (master)
// and the memory responder (slave).
//   write channel : write_addr, iData, write  -> write_waitrequest
//   read channel  : read_addr, read           -> oData, read_waitrequest
// ----------------------------------------------------------------------------
interface ddr2_port_responder_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       write_addr;
    logic [DATA_W-1:0] iData;
    logic              write;
    logic              write_waitrequest;
    logic [31:0]       read_addr;
    logic              read;
    logic [DATA_W-1:0] oData;
    logic              read_waitrequest;

    modport master (
        output write_addr, iData, write, read_addr, read,
        input  write_waitrequest, oData, read_waitrequest
    );

    modport slave (
        input  write_addr, iData, write, read_addr, read,
        output write_waitrequest, oData, read_waitrequest
    );
endinterface

// File: rtl/ddr2_resp_ram.sv
// ----------------------------------------------------------------------------
// ddr2_resp_ram
// Single-port synchronous RAM, DEPTH x DATA_W, one-cycle read, write-first.
//   clk   : clock
//   en    : access enable (q only changes on an enabled access)
//   we    : write enable (with en)
//   addr  : word index
//   wdata : write data
//   q     : read data, registered
// ----------------------------------------------------------------------------
module ddr2_resp_ram #(
    parameter int DEPTH  = 640,
    parameter int IDX_W  = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write-first: a write also presents the new word on q.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                q         <= wdata;
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ddr2_port_responder.sv
// ----------------------------------------------------------------------------
// ddr2_port_responder
// Memory-side responder for the frame-buffer write/read conduit, backed by an
// on-chip RAM with programmable access latency. Accesses are serialized by a
// single FSM; simultaneous requests alternate by round robin.
//   ctrl_clk : clock
//   reset    : synchronous, active-high
//   bus      : ddr2_port_responder_if.slave (both channels)
//   addr_err : sticky, a misaligned address was accepted
//   wr_count : completed writes (wraps)
//   rd_count : completed reads (wraps)
// Optional build macro DDR2_RESP_JITTER_EN: a free-running LFSR adds 0-3 extra
// wait cycles, sampled at grant, to every transfer.
// ----------------------------------------------------------------------------
module ddr2_port_responder
    import ddr2_resp_pkg::*;
#(
    parameter int DEPTH      = 640,
    parameter int IDX_W      = 10,
    parameter int DATA_W     = 32,
    parameter int WR_LATENCY = 2,
    parameter int RD_LATENCY = 4
) (
    input  logic                  ctrl_clk,
    input  logic                  reset,
    ddr2_port_responder_if.slave  bus,
    output logic                  addr_err,
    output logic [31:0]           wr_count,
    output logic [31:0]           rd_count
);

    localparam logic [7:0] WR_LOAD = 8'(WR_LATENCY - 1);
    localparam logic [7:0] RD_LOAD = 8'(RD_LATENCY - 1);

    resp_state_t       state;
    grant_t            last_grant;
    logic [7:0]        lat_cnt;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] odata_q;
    logic              wr_wait_q;
    logic              rd_wait_q;
    logic [7:0]        jitter;
    logic              grant_wr;
    logic              grant_rd;
    logic [7:0]        wr_load;
    logic [7:0]        rd_load;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_done;
    logic              rd_done;
    logic              rd_issue;
    logic              ram_en;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q;

`ifdef DDR2_RESP_JITTER_EN
    logic [15:0] lfsr;

    // Galois LFSR stepping every cycle; its two low bits become extra wait
    // cycles for whichever transfer is granted in that cycle.
    always_ff @(posedge ctrl_clk) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    assign jitter = {6'b000000, lfsr[1:0]};
`else
    assign jitter = 8'd0;
`endif

    // Arbitration: a lone request wins; when both are high the channel that
    // did not complete last goes first.
    always_comb begin
        grant_wr = bus.write && (!bus.read || (last_grant == GRANT_READ));
        grant_rd = bus.read && !grant_wr;
    end

    assign wr_load = WR_LOAD + jitter;
    assign rd_load = RD_LOAD + jitter;
    assign wr_idx  = IDX_W'(byte_to_word(bus.write_addr, IDX_W, DEPTH));
    assign rd_idx  = IDX_W'(byte_to_word(bus.read_addr, IDX_W, DEPTH));

    // The RAM read is issued one cycle before read completion so that its
    // registered output is valid in the completion cycle itself. Reset masks
    // the write strobe so an aborted completion never reaches the array.
    assign wr_done  = (state == ST_WR_WAIT) && (lat_cnt == 8'd0);
    assign rd_done  = (state == ST_RD_WAIT) && (lat_cnt == 8'd0);
    assign rd_issue = (state == ST_RD_WAIT) && (lat_cnt == 8'd1);
    assign ram_en   = (wr_done || rd_issue) && !reset;
    assign ram_we   = wr_done && !reset;

    ddr2_resp_ram #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (ctrl_clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (idx_q),
        .wdata (wdata_q),
        .q     (ram_q)
    );

    assign bus.write_waitrequest = wr_wait_q;
    assign bus.read_waitrequest  = rd_wait_q;
    assign bus.oData             = rd_done ? ram_q : odata_q;

    // Main transfer FSM. Waitrequests are registered, so each one is dropped
    // on the edge that enters the completion cycle (lat_cnt reaching 0) and
    // raised again on the edge that leaves it. Requests are ignored outside
    // IDLE, so a request dropped mid-wait still completes and is counted.
    always_ff @(posedge ctrl_clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_READ;
            lat_cnt    <= 8'd0;
            idx_q      <= '0;
            wdata_q    <= '0;
            odata_q    <= '0;
            wr_wait_q  <= 1'b1;
            rd_wait_q  <= 1'b1;
            addr_err   <= 1'b0;
            wr_count   <= 32'd0;
            rd_count   <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_wr) begin
                        idx_q     <= wr_idx;
                        wdata_q   <= bus.iData;
                        lat_cnt   <= wr_load;
                        wr_wait_q <= (wr_load != 8'd0);
                        if (bus.write_addr[1:0] != 2'b00) addr_err <= 1'b1;
                        state     <= ST_WR_WAIT;
                    end else if (grant_rd) begin
                        idx_q     <= rd_idx;
                        lat_cnt   <= rd_load;
                        if (bus.read_addr[1:0] != 2'b00) addr_err <= 1'b1;
                        state     <= ST_RD_WAIT;
                    end
                end
                ST_WR_WAIT: begin
                    if (lat_cnt == 8'd0) begin
                        wr_wait_q  <= 1'b1;
                        wr_count   <= wr_count + 32'd1;
                        last_grant <= GRANT_WRITE;
                        state      <= ST_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                        if (lat_cnt == 8'd1) wr_wait_q <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    if (lat_cnt == 8'd0) begin
                        rd_wait_q  <= 1'b1;
                        odata_q    <= ram_q;
                        rd_count   <= rd_count + 32'd1;
                        last_grant <= GRANT_READ;
                        state      <= ST_DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                        if (lat_cnt == 8'd1) rd_wait_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_port_responder.sv
// ----------------------------------------------------------------------------
// tb_ddr2_port_responder
// Self-checking bench for ddr2_port_responder (default build, no jitter).
// A behavioural model (word array, counters, sticky error flag, transfer
// timing derived from the latencies) predicts every observed value.
// ----------------------------------------------------------------------------
module tb_ddr2_port_responder;

    localparam int DEPTH  = 640;
    localparam int WR_LAT = 2;
    localparam int RD_LAT = 4;

    logic        ctrl_clk = 1'b0;
    logic        reset;
    logic        addr_err;
    logic [31:0] wr_count;
    logic [31:0] rd_count;

    ddr2_port_responder_if #(.DATA_W(32)) bus ();

    ddr2_port_responder #(
        .DEPTH      (DEPTH),
        .IDX_W      (10),
        .DATA_W     (32),
        .WR_LATENCY (WR_LAT),
        .RD_LATENCY (RD_LAT)
    ) dut (
        .ctrl_clk (ctrl_clk),
        .reset    (reset),
        .bus      (bus.slave),
        .addr_err (addr_err),
        .wr_count (wr_count),
        .rd_count (rd_count)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    logic [31:0] ref_mem [DEPTH];
    int          exp_wr;
    int          exp_rd;
    bit          exp_err;
    bit          after_completion;
    int          test_count;
    int          fail_count;

    // Word index as the memory map defines it: word number, 10-bit field, then
    // wrapped into one 640-word line.
    function automatic int ref_index(input logic [31:0] byte_addr);
        int unsigned word_no;
        word_no = (byte_addr / 4) % 1024;
        return int'(word_no % DEPTH);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One transfer on one channel. Completion is expected latency+1 sampled
    // cycles after the request is driven from IDLE, one more when it is driven
    // during the DONE bubble after a held request. hold=1 leaves the request
    // high so the next call continues back-to-back.
    task automatic applyStimulus(input bit is_wr, input logic [31:0] addr,
                                 input logic [31:0] data, input bit hold);
        int n;
        int exp_n;
        int idx;
        @(posedge ctrl_clk); #1;
        if (is_wr) begin
            bus.read       = 1'b0;
            bus.write      = 1'b1;
            bus.write_addr = addr;
            bus.iData      = data;
        end else begin
            bus.write      = 1'b0;
            bus.read       = 1'b1;
            bus.read_addr  = addr;
        end
        exp_n = (is_wr ? WR_LAT : RD_LAT) + 1 + (after_completion ? 1 : 0);
        idx   = ref_index(addr);
        n     = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge ctrl_clk);
            n++;
            checkOutput("other_waitreq",
                        {31'd0, is_wr ? bus.read_waitrequest : bus.write_waitrequest}, 32'd1);
            if ((is_wr ? bus.write_waitrequest : bus.read_waitrequest) === 1'b0) break;
        end
        checkOutput(is_wr ? "wr_latency" : "rd_latency", 32'(n), 32'(exp_n));
        if (is_wr) begin
            ref_mem[idx] = data;
            exp_wr++;
        end else begin
            checkOutput("rd_data", bus.oData, ref_mem[idx]);
            exp_rd++;
        end
        if (addr[1:0] != 2'b00) exp_err = 1'b1;
        after_completion = hold;
        if (!hold) begin
            @(posedge ctrl_clk); #1;
            bus.write = 1'b0;
            bus.read  = 1'b0;
            @(negedge ctrl_clk);
            checkOutput("done_wr_waitreq", {31'd0, bus.write_waitrequest}, 32'd1);
            checkOutput("done_rd_waitreq", {31'd0, bus.read_waitrequest}, 32'd1);
            if (!is_wr) checkOutput("rd_data_held", bus.oData, ref_mem[idx]);
            checkOutput("wr_count", wr_count, 32'(exp_wr));
            checkOutput("rd_count", rd_count, 32'(exp_rd));
            checkOutput("addr_err", {31'd0, addr_err}, {31'd0, exp_err});
        end
    endtask

    task automatic doReset();
        @(posedge ctrl_clk); #1;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        reset     = 1'b1;
        @(posedge ctrl_clk); #1;
        reset = 1'b0;
        exp_wr = 0;
        exp_rd = 0;
        exp_err = 1'b0;
        after_completion = 1'b0;
    endtask

    // Bounded run time: a hung handshake still ends with a report.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] rd_base;
        logic [31:0] rand_addr;
        bit          hold;
        test_count = 0;
        fail_count = 0;
        exp_wr = 0;
        exp_rd = 0;
        exp_err = 1'b0;
        after_completion = 1'b0;
        bus.write = 1'b0;
        bus.read = 1'b0;
        bus.write_addr = '0;
        bus.read_addr = '0;
        bus.iData = '0;
        reset = 1'b1;
        repeat (3) @(posedge ctrl_clk);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge ctrl_clk);
        checkOutput("rst_wr_waitreq", {31'd0, bus.write_waitrequest}, 32'd1);
        checkOutput("rst_rd_waitreq", {31'd0, bus.read_waitrequest}, 32'd1);
        checkOutput("rst_odata", bus.oData, 32'd0);
        checkOutput("rst_addr_err", {31'd0, addr_err}, 32'd0);
        checkOutput("rst_wr_count", wr_count, 32'd0);
        checkOutput("rst_rd_count", rd_count, 32'd0);

        // Basic write then read of the same word.
        applyStimulus(1'b1, 32'h10, 32'h11223344, 1'b0);
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);
        checkOutput("basic_rd_const", bus.oData, 32'h11223344);

        // Simultaneous requests right after reset: write goes first.
        doReset();
        @(posedge ctrl_clk); #1;
        bus.write      = 1'b1;
        bus.write_addr = 32'h20;
        bus.iData      = 32'hAABBCCDD;
        bus.read       = 1'b1;
        bus.read_addr  = 32'h20;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge ctrl_clk);
            n++;
            checkOutput("both_rd_held_off", {31'd0, bus.read_waitrequest}, 32'd1);
            if (bus.write_waitrequest === 1'b0) break;
        end
        checkOutput("both_wr_latency", 32'(n), 32'(WR_LAT + 1));
        ref_mem[ref_index(32'h20)] = 32'hAABBCCDD;
        exp_wr++;
        @(posedge ctrl_clk); #1;
        bus.write = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge ctrl_clk);
            n++;
            checkOutput("both_wr_idle", {31'd0, bus.write_waitrequest}, 32'd1);
            if (bus.read_waitrequest === 1'b0) break;
        end
        checkOutput("both_rd_latency", 32'(n), 32'(RD_LAT + 2));
        checkOutput("both_rd_data", bus.oData, 32'hAABBCCDD);
        exp_rd++;
        @(posedge ctrl_clk); #1;
        bus.read = 1'b0;
        @(negedge ctrl_clk);
        checkOutput("both_wr_count", wr_count, 32'd1);
        checkOutput("both_rd_count", rd_count, 32'd1);

        // Address wrap: 640 words past index 0 lands on index 0.
        applyStimulus(1'b1, 32'hA00, 32'hCAFE0A00, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("wrap_rd_const", bus.oData, 32'hCAFE0A00);

        // Misaligned read sets the sticky error; aligned traffic keeps it.
        applyStimulus(1'b1, 32'h4, 32'h5A5A0004, 1'b0);
        applyStimulus(1'b0, 32'h6, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h8, 32'h0BADF00D, 1'b0);
        applyStimulus(1'b0, 32'h8, 32'h0, 1'b0);
        checkOutput("err_sticky", {31'd0, addr_err}, 32'd1);

        // Reset in the middle of a read wait, then a normal read.
        @(posedge ctrl_clk); #1;
        bus.read      = 1'b1;
        bus.read_addr = 32'h10;
        @(negedge ctrl_clk);
        @(negedge ctrl_clk);
        reset    = 1'b1;
        bus.read = 1'b0;
        @(negedge ctrl_clk);
        checkOutput("midrst_wr_waitreq", {31'd0, bus.write_waitrequest}, 32'd1);
        checkOutput("midrst_rd_waitreq", {31'd0, bus.read_waitrequest}, 32'd1);
        checkOutput("midrst_wr_count", wr_count, 32'd0);
        checkOutput("midrst_rd_count", rd_count, 32'd0);
        checkOutput("midrst_addr_err", {31'd0, addr_err}, 32'd0);
        @(posedge ctrl_clk); #1;
        reset = 1'b0;
        exp_wr = 0;
        exp_rd = 0;
        exp_err = 1'b0;
        after_completion = 1'b0;
        applyStimulus(1'b0, 32'h10, 32'h0, 1'b0);

        // One full line written back-to-back, then read back-to-back.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 32'(i * 4), $urandom, (i != DEPTH - 1));
        end
        rd_base = rd_count;
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 32'(i * 4), 32'h0, (i != DEPTH - 1));
        end
        checkOutput("line_rd_count", rd_count - rd_base, 32'd640);

        // Random mix of reads and writes across the whole 10-bit index field.
        for (int i = 0; i < 60; i++) begin
            rand_addr = 32'($urandom_range(0, 1023)) * 32'd4;
            hold      = (i != 59) && ($urandom_range(0, 1) == 1);
            applyStimulus($urandom_range(0, 1) == 1, rand_addr, $urandom, hold);
        end

        @(posedge ctrl_clk); #1;
        bus.write = 1'b0;
        bus.read  = 1'b0;
        repeat (2) @(posedge ctrl_clk);
        @(negedge ctrl_clk);
        checkOutput("final_wr_count", wr_count, 32'(exp_wr));
        checkOutput("final_rd_count", rd_count, 32'(exp_rd));

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
